uart_tx_framer: RTL

//  Parametrised UART TX message framer: successor to the fixed 48-bit CORDIC result packer.

---
 rtl/uart_tx_framer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: frames N_WORDS x DATA_W result beats into
// HEADER + payload + CRC-8 byte streams for the uart_tx serialiser.
// Echo commands (E1/E2) produce HEADER + cmd + CRC frames instead.
module uart_tx_framer #(
    parameter int unsigned DATA_W   = 48,
    parameter int unsigned N_WORDS  = 2,
    parameter logic [7:0]  HEADER   = 8'h5A,
    parameter logic [7:0]  CRC_POLY = 8'h9B,
    parameter logic [7:0]  CRC_INIT = 8'h00
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [7:0]                  i_cmd,
    input  logic                        i_cmd_valid,
    input  logic [7:0]                  i_burst_cnt,
    input  logic                        i_abort,
    input  logic [N_WORDS*DATA_W-1:0]   i_data,
    input  logic                        i_data_valid,
    output logic                        o_data_ready,
    output logic [7:0]                  o_tx_byte,
    output logic                        o_tx_valid,
    input  logic                        i_tx_ready,
    output logic                        o_busy,
    output logic                        o_err
);

    localparam int unsigned BEAT_W = N_WORDS * DATA_W;
    localparam int unsigned NB     = BEAT_W / 8;
    localparam int unsigned IDX_W  = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [7:0] CMD_SINGLE  = 8'hD1;
    localparam logic [7:0] CMD_BURST   = 8'hD2;
    localparam logic [7:0] CMD_DISABLE = 8'hE1;
    localparam logic [7:0] CMD_ENABLE  = 8'hE2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_HDR,
        S_PAYLOAD,
        S_ECHO,
        S_CRC
    } state_t;

    typedef enum logic [1:0] {
        MODE_DATA,
        MODE_ECHO,
        MODE_EMPTY
    } mode_t;

    state_t            state_q, state_d;
    mode_t             mode_q;
    logic [7:0]        rem_q;
    logic [7:0]        cmd_q;
    logic [7:0]        crc_q;
    logic [IDX_W-1:0]  idx_q;
    logic [BEAT_W-1:0] beat_q;
    logic              hdr_sent_q;
    logic              err_q;
    logic [7:0]        payload_byte;
    logic [7:0]        tx_byte;
    logic              accept;
    logic              last_byte;

    // One MSB-first CRC-8 update over a whole byte, no reflection.
    function automatic logic [7:0] crc_fold(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

    assign last_byte    = (idx_q == IDX_W'(NB - 1));
    assign accept       = o_tx_valid && i_tx_ready;
    assign o_tx_byte    = tx_byte;
    assign o_busy       = (state_q != S_IDLE);
    assign o_err        = err_q;

    // Select the current payload byte: word0 first, each word LSByte first,
    // which is simply the beat read out byte by byte from bit 0 upwards.
    always_comb begin
        payload_byte = 8'h00;
        for (int b = 0; b < NB; b++) begin
            if (idx_q == IDX_W'(b)) begin
                payload_byte = beat_q[b*8 +: 8];
            end
        end
    end

    // Frame sequencing: next state plus the byte/handshake outputs.
    always_comb begin
        state_d      = state_q;
        o_tx_valid   = 1'b0;
        o_data_ready = 1'b0;
        tx_byte      = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    case (i_cmd)
                        CMD_SINGLE:               state_d = S_WAIT_DATA;
                        CMD_BURST:                state_d = (i_burst_cnt == 8'd0) ? S_HDR : S_WAIT_DATA;
                        CMD_DISABLE, CMD_ENABLE:  state_d = S_HDR;
                        default:                  state_d = S_IDLE;
                    endcase
                end
            end
            S_WAIT_DATA: begin
                o_data_ready = 1'b1;
                if (i_data_valid) begin
                    state_d = hdr_sent_q ? S_PAYLOAD : S_HDR;
                end
            end
            S_HDR: begin
                o_tx_valid = 1'b1;
                tx_byte    = HEADER;
                if (i_tx_ready) begin
                    case (mode_q)
                        MODE_ECHO:  state_d = S_ECHO;
                        MODE_EMPTY: state_d = S_CRC;
                        default:    state_d = S_PAYLOAD;
                    endcase
                end
            end
            S_PAYLOAD: begin
                o_tx_valid = 1'b1;
                tx_byte    = payload_byte;
                if (i_tx_ready && last_byte) begin
                    state_d = (rem_q != 8'd0) ? S_WAIT_DATA : S_CRC;
                end
            end
            S_ECHO: begin
                o_tx_valid = 1'b1;
                tx_byte    = cmd_q;
                if (i_tx_ready) begin
                    state_d = S_CRC;
                end
            end
            S_CRC: begin
                o_tx_valid = 1'b1;
                tx_byte    = crc_q;
                if (i_tx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (i_abort) begin
            state_d = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame context: command decode, beat capture, byte counter, running CRC, error pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q     <= MODE_DATA;
            rem_q      <= 8'd0;
            cmd_q      <= 8'd0;
            crc_q      <= CRC_INIT;
            idx_q      <= '0;
            beat_q     <= '0;
            hdr_sent_q <= 1'b0;
            err_q      <= 1'b0;
        end else if (i_abort) begin
            rem_q      <= 8'd0;
            crc_q      <= CRC_INIT;
            idx_q      <= '0;
            hdr_sent_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (i_cmd_valid) begin
                if (state_q != S_IDLE) begin
                    err_q <= 1'b1;
                end else begin
                    hdr_sent_q <= 1'b0;
                    idx_q      <= '0;
                    case (i_cmd)
                        CMD_SINGLE: begin
                            rem_q  <= 8'd1;
                            mode_q <= MODE_DATA;
                        end
                        CMD_BURST: begin
                            rem_q  <= i_burst_cnt;
                            mode_q <= (i_burst_cnt == 8'd0) ? MODE_EMPTY : MODE_DATA;
                        end
                        CMD_DISABLE, CMD_ENABLE: begin
                            cmd_q  <= i_cmd;
                            mode_q <= MODE_ECHO;
                        end
                        default: err_q <= 1'b1;
                    endcase
                end
            end
            if ((state_q == S_WAIT_DATA) && i_data_valid) begin
                beat_q <= i_data;
                rem_q  <= rem_q - 8'd1;
            end
            if (accept) begin
                if (state_q == S_CRC) begin
                    crc_q      <= CRC_INIT;
                    hdr_sent_q <= 1'b0;
                end else begin
                    crc_q <= crc_fold(crc_q, tx_byte);
                end
                if (state_q == S_HDR) begin
                    hdr_sent_q <= 1'b1;
                end
                if (state_q == S_PAYLOAD) begin
                    idx_q <= last_byte ? '0 : idx_q + IDX_W'(1);
                end
            end
        end
    end

endmodule
